lcd_refresh_ctrl: RTL and testbench
===================================

Name: lcd_refresh_ctrl

Overview:
Sequencer that drives the 16x2 HD44780 character LCD bus for the return-and-earn machine. It waits out power-up, runs the init command sequence, then refreshes all 32 character cells continuously from an external message formatter. It selects the active screen (normal counts / done / error) once per frame and issues a display clear whenever the screen changes. It sits between the count/status logic and the LCD pins, replacing free-running test sequencing with a deterministic frame scheduler.

Parameters:
SETUP_CYC, 4, cycles RS/DATA are stable with EN low before the EN pulse (>=1)
EN_CYC, 16, cycles EN held high (320 ns at 50 MHz)
CMD_WAIT_CYC, 2500, EN-low wait after any write except clear (50 us)
CLR_WAIT_CYC, 100000, EN-low wait after clear command 0x01 (2 ms)
PWRUP_CYC, 1000000, wait after reset before the first command (20 ms)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
done  in  1  transaction complete status
error  in  1  machine fault status
char_addr  out  5  cell index requested from formatter: 0-15 line 1, 16-31 line 2
char_data  in  8  ASCII code for char_addr; combinational, valid 1 cycle after char_addr changes
screen_id  out  2  screen latched for the current frame: 0 normal, 1 done, 2 error
frame_done  out  1  one-cycle pulse after the last cell of a frame is written
init_done  out  1  high once the init sequence completes; cleared only by reset
LCD_DATA  out  8  LCD data bus
LCD_RS  out  1  0 command, 1 data
LCD_RW  out  1  tied 0 (write only)
LCD_EN  out  1  LCD enable strobe

Behaviour:
- Reset (async, any state): LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, char_addr=0, screen_id=0, frame_done=0, init_done=0; FSM goes to PWRUP. A reset mid-write drops EN immediately, and the full power-up wait restarts.
- Write primitive, used for every command/data byte:
  - SETUP: RS/DATA driven and EN=0 for SETUP_CYC cycles.
  - PULSE: EN=1 for EN_CYC cycles.
  - HOLD: EN=0 for CMD_WAIT_CYC cycles, or CLR_WAIT_CYC if the byte is command 0x01.
  - RS/DATA stay stable from the SETUP start to the HOLD end. One shared down-counter covers all waits.
- FSM states: PWRUP -> INIT -> SEL -> [CLR] -> L1ADDR -> L1CHR -> L2ADDR -> L2CHR -> FEND -> SEL.
  - PWRUP: waits PWRUP_CYC cycles, all outputs at reset values.
  - INIT: commands 0x38, 0x0C, 0x06, 0x01 in order. init_done rises in the cycle after the 0x01 HOLD ends.
  - SEL: one cycle. Latches screen_id = 2 if error, else 1 if done, else 0 (error has priority). If the new value differs from the previous frame's value, go to CLR (command 0x01); otherwise go to L1ADDR. The first frame after init never clears.
  - L1ADDR: command 0x80. L2ADDR: command 0xC0.
  - L1CHR / L2CHR: 16 data writes each (RS=1).
    - Per cell: FETCH drives char_addr for 2 cycles, registers char_data into LCD_DATA on the 2nd cycle, then runs the write primitive.
    - char_addr runs 0..15 on line 1 and 16..31 on line 2. It wraps to 0 at FEND and holds its value between fetches.
  - FEND: frame_done=1 for exactly one cycle, then SEL.
- Status sampling:
  - done/error are sampled only in SEL. Changes mid-frame take effect at the next frame boundary.
  - Simultaneous done=1 and error=1 gives screen_id=2.
- char_data is sampled only on the second FETCH cycle; changes at other times are ignored.
- Frame length is deterministic. With no clear: 34 writes, each SETUP_CYC+EN_CYC+CMD_WAIT_CYC cycles, plus 32*2 fetch cycles, SEL and FEND.

Test Plan:
- Params SETUP=2, EN=2, CMD_WAIT=4, CLR_WAIT=10, PWRUP=20; release rst -> EN stays 0 for 20 cycles; then bytes 0x38, 0x0C, 0x06, 0x01 with RS=0; EN high exactly 2 cycles each; gap after 0x01 is 10 cycles; init_done rises after it.
- Formatter returns 0x41+char_addr -> line 1 receives 0x80 then 0x41..0x50 (RS=1); line 2 receives 0xC0 then 0x51..0x60; frame_done pulses once per frame; LCD_DATA is stable throughout every EN-high window.
- done=1 mid-frame 1 -> frame 1 completes with screen_id=0; next SEL latches 1 and issues 0x01 before 0x80; a following frame with done still 1 issues no clear.
- done=1 and error=1 together -> screen_id=2; error deasserts while done stays 1 -> next frame screen_id=1, preceded by a clear.
- rst pulse while EN=1 during a line-2 data write -> EN=0 asynchronously, all outputs at reset values, init_done=0; full PWRUP + INIT repeats.
- Check LCD_RW=0 for the whole simulation; check char_addr never exceeds 31 and returns to 0 after each FEND.

Source files
------------

// File: rtl/lcd_refresh_ctrl.sv
`timescale 1ns/1ps
// lcd_refresh_ctrl
// Frame scheduler for a 16x2 HD44780 character LCD (write-only bus).
// After reset it waits out LCD power-up and sends the init commands
// 0x38, 0x0C, 0x06 and 0x01. It then refreshes all 32 cells without stopping,
// using characters from an external formatter. The screen (normal/done/error)
// is chosen once per frame. A clear is issued whenever the screen changes.
//
// Ports:
//   CLOCK_50   in   system clock
//   rst        in   asynchronous active-high reset
//   done       in   transaction-complete status (sampled once per frame)
//   error      in   machine-fault status (sampled once per frame, has priority)
//   char_addr  out  cell index for the formatter (0-15 line 1, 16-31 line 2)
//   char_data  in   ASCII code for char_addr (combinational from the formatter)
//   screen_id  out  screen of the current frame: 0 normal, 1 done, 2 error
//   frame_done out  one-cycle pulse after the last cell of a frame is written
//   init_done  out  high once the init sequence has finished
//   LCD_DATA   out  LCD data bus
//   LCD_RS     out  0 command, 1 data
//   LCD_RW     out  always 0
//   LCD_EN     out  LCD enable strobe
module lcd_refresh_ctrl #(
    parameter int SETUP_CYC    = 4,
    parameter int EN_CYC       = 16,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000,
    parameter int PWRUP_CYC    = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       done,
    input  logic       error,
    output logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic [1:0] screen_id,
    output logic       frame_done,
    output logic       init_done,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    // The shared down-counter must be wide enough for the longest wait.
    localparam int MAX_SE   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_WT   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
    localparam int MAX_SEW  = (MAX_SE > MAX_WT) ? MAX_SE : MAX_WT;
    localparam int MAX_CYC  = (PWRUP_CYC > MAX_SEW) ? PWRUP_CYC : MAX_SEW;
    localparam int CNT_W    = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYC - 1);

    typedef enum logic [3:0] {
        S_PWRUP, S_INIT, S_SEL, S_CLR, S_L1ADDR, S_L1CHR, S_L2ADDR, S_L2CHR, S_FEND
    } state_t;

    // Sub-phase of the byte-write primitive; IDLE means no write is in progress.
    typedef enum logic [2:0] {
        PH_IDLE, PH_FETCH, PH_SETUP, PH_PULSE, PH_HOLD
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            first_q, first_d;
    logic [4:0]      char_addr_q, char_addr_d;
    logic [1:0]      screen_id_q, screen_id_d;
    logic            frame_done_q, frame_done_d;
    logic            init_done_q, init_done_d;
    logic [7:0]      lcd_data_q, lcd_data_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic            lcd_en_q, lcd_en_d;

    logic            cnt_zero_s;
    logic            is_clr_s;
    logic            wr_end_s;
    logic            start_wr_s;
    logic [7:0]      wr_byte_s;
    logic            wr_rs_s;
    logic [1:0]      new_screen_s;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    function automatic logic [1:0] sel_screen(input logic d, input logic e);
        if (e) begin
            sel_screen = 2'd2;
        end else if (d) begin
            sel_screen = 2'd1;
        end else begin
            sel_screen = 2'd0;
        end
    endfunction

    // Next-state logic: the write-primitive phases first, then frame sequencing.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        first_d      = first_q;
        char_addr_d  = char_addr_q;
        screen_id_d  = screen_id_q;
        frame_done_d = 1'b0;
        init_done_d  = init_done_q;
        lcd_data_d   = lcd_data_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_en_d     = 1'b0;
        start_wr_s   = 1'b0;
        wr_byte_s    = 8'h00;
        wr_rs_s      = 1'b0;
        wr_end_s     = 1'b0;
        cnt_zero_s   = (cnt_q == CNT_ZERO);
        is_clr_s     = ~lcd_rs_q & (lcd_data_q == 8'h01);
        new_screen_s = sel_screen(done, error);

        case (phase_q)
            PH_FETCH: begin
                // Second fetch cycle: formatter output has settled on char_addr.
                if (cnt_zero_s) begin
                    start_wr_s = 1'b1;
                    wr_byte_s  = char_data;
                    wr_rs_s    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PH_SETUP: begin
                if (cnt_zero_s) begin
                    phase_d  = PH_PULSE;
                    lcd_en_d = 1'b1;
                    cnt_d    = LD_EN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PH_PULSE: begin
                if (cnt_zero_s) begin
                    phase_d = PH_HOLD;
                    cnt_d   = is_clr_s ? LD_CLR : LD_CMD;
                end else begin
                    lcd_en_d = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                end
            end
            PH_HOLD: begin
                if (cnt_zero_s) begin
                    wr_end_s = 1'b1;
                    phase_d  = PH_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase

        case (state_q)
            S_PWRUP: begin
                if (cnt_zero_s) begin
                    state_d    = S_INIT;
                    idx_d      = 2'd0;
                    start_wr_s = 1'b1;
                    wr_byte_s  = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_INIT: begin
                if (wr_end_s && (idx_q == 2'd3)) begin
                    init_done_d = 1'b1;
                    state_d     = S_SEL;
                end else if (wr_end_s) begin
                    idx_d      = idx_q + 2'd1;
                    start_wr_s = 1'b1;
                    wr_byte_s  = init_cmd(idx_q + 2'd1);
                end else begin
                    state_d = S_INIT;
                end
            end
            S_SEL: begin
                screen_id_d = new_screen_s;
                first_d     = 1'b0;
                start_wr_s  = 1'b1;
                // The init sequence already cleared the panel, so the first frame skips it.
                if (!first_q && (new_screen_s != screen_id_q)) begin
                    state_d   = S_CLR;
                    wr_byte_s = 8'h01;
                end else begin
                    state_d   = S_L1ADDR;
                    wr_byte_s = 8'h80;
                end
            end
            S_CLR: begin
                if (wr_end_s) begin
                    state_d    = S_L1ADDR;
                    start_wr_s = 1'b1;
                    wr_byte_s  = 8'h80;
                end else begin
                    state_d = S_CLR;
                end
            end
            S_L1ADDR: begin
                if (wr_end_s) begin
                    state_d = S_L1CHR;
                    phase_d = PH_FETCH;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = S_L1ADDR;
                end
            end
            S_L1CHR: begin
                if (wr_end_s && (char_addr_q == 5'd15)) begin
                    state_d    = S_L2ADDR;
                    start_wr_s = 1'b1;
                    wr_byte_s  = 8'hC0;
                end else if (wr_end_s) begin
                    char_addr_d = char_addr_q + 5'd1;
                    phase_d     = PH_FETCH;
                    cnt_d       = CNT_ONE;
                end else begin
                    state_d = S_L1CHR;
                end
            end
            S_L2ADDR: begin
                if (wr_end_s) begin
                    state_d     = S_L2CHR;
                    char_addr_d = char_addr_q + 5'd1;
                    phase_d     = PH_FETCH;
                    cnt_d       = CNT_ONE;
                end else begin
                    state_d = S_L2ADDR;
                end
            end
            S_L2CHR: begin
                if (wr_end_s && (char_addr_q == 5'd31)) begin
                    state_d      = S_FEND;
                    char_addr_d  = 5'd0;
                    frame_done_d = 1'b1;
                end else if (wr_end_s) begin
                    char_addr_d = char_addr_q + 5'd1;
                    phase_d     = PH_FETCH;
                    cnt_d       = CNT_ONE;
                end else begin
                    state_d = S_L2CHR;
                end
            end
            S_FEND: begin
                state_d = S_SEL;
            end
            default: begin
                state_d = S_PWRUP;
                phase_d = PH_IDLE;
                cnt_d   = LD_PWRUP;
            end
        endcase

        // RS/DATA are loaded once at the start of SETUP and held until HOLD ends.
        if (start_wr_s) begin
            lcd_data_d = wr_byte_s;
            lcd_rs_d   = wr_rs_s;
            phase_d    = PH_SETUP;
            cnt_d      = LD_SETUP;
        end else begin
            lcd_data_d = lcd_data_d;
        end
    end

    // State and output registers; reset drops EN at once and restarts power-up.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q      <= S_PWRUP;
            phase_q      <= PH_IDLE;
            cnt_q        <= LD_PWRUP;
            idx_q        <= 2'd0;
            first_q      <= 1'b1;
            char_addr_q  <= 5'd0;
            screen_id_q  <= 2'd0;
            frame_done_q <= 1'b0;
            init_done_q  <= 1'b0;
            lcd_data_q   <= 8'h00;
            lcd_rs_q     <= 1'b0;
            lcd_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            first_q      <= first_d;
            char_addr_q  <= char_addr_d;
            screen_id_q  <= screen_id_d;
            frame_done_q <= frame_done_d;
            init_done_q  <= init_done_d;
            lcd_data_q   <= lcd_data_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_en_q     <= lcd_en_d;
        end
    end

    assign char_addr  = char_addr_q;
    assign screen_id  = screen_id_q;
    assign frame_done = frame_done_q;
    assign init_done  = init_done_q;
    assign LCD_DATA   = lcd_data_q;
    assign LCD_RS     = lcd_rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = lcd_en_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
`timescale 1ns/1ps
// Directed bench for lcd_refresh_ctrl with small timing parameters.
// A negedge monitor logs every EN-high write ({RS,DATA}, time, screen) and every frame_done pulse.
// The main sequence compares the logs against hand-computed values.
module tb_lcd_refresh_ctrl;

    localparam int SETUP = 2;
    localparam int ENC   = 2;
    localparam int CMDW  = 4;
    localparam int CLRW  = 10;
    localparam int PWR   = 20;
    localparam int PER   = 20;

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b1;
    logic       done     = 1'b0;
    logic       error    = 1'b0;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic [1:0] screen_id;
    logic       frame_done;
    logic       init_done;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    lcd_refresh_ctrl #(
        .SETUP_CYC(SETUP), .EN_CYC(ENC), .CMD_WAIT_CYC(CMDW),
        .CLR_WAIT_CYC(CLRW), .PWRUP_CYC(PWR)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .done(done), .error(error),
        .char_addr(char_addr), .char_data(char_data), .screen_id(screen_id),
        .frame_done(frame_done), .init_done(init_done), .LCD_DATA(LCD_DATA),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Formatter model: cell n shows ASCII 'A'+n.
    assign char_data = 8'h41 + {3'b000, char_addr};

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] wr_b[$];
    time        wr_t[$];
    logic [1:0] wr_s[$];
    time        fd_t[$];
    logic [1:0] fd_s[$];
    time        id_t[$];

    int   rw_bad = 0, en_len_bad = 0, stab_bad = 0, fd_wide_bad = 0, fd_addr_bad = 0, addr_bad = 0;
    logic en_prev = 1'b0, fd_prev = 1'b0, id_prev = 1'b0;
    int   en_len = 0;
    logic [8:0] en_val = 9'h000;

    always @(negedge CLOCK_50) begin
        if (LCD_RW !== 1'b0) rw_bad++;
        if (rst) begin
            en_prev = 1'b0;
            fd_prev = 1'b0;
            id_prev = 1'b0;
        end else begin
            if (LCD_EN && !en_prev) begin
                wr_b.push_back({LCD_RS, LCD_DATA});
                wr_t.push_back($time);
                wr_s.push_back(screen_id);
                en_len = 1;
                en_val = {LCD_RS, LCD_DATA};
                if (LCD_RS && ({3'b000, char_addr} !== (LCD_DATA - 8'h41))) addr_bad++;
            end else if (LCD_EN) begin
                en_len++;
                if ({LCD_RS, LCD_DATA} !== en_val) stab_bad++;
            end else if (en_prev && (en_len != ENC)) begin
                en_len_bad++;
            end
            if (frame_done) begin
                if (fd_prev) fd_wide_bad++;
                else begin
                    fd_t.push_back($time);
                    fd_s.push_back(screen_id);
                end
                if (char_addr !== 5'd0) fd_addr_bad++;
            end
            if (init_done && !id_prev) id_t.push_back($time);
            en_prev = LCD_EN;
            fd_prev = frame_done;
            id_prev = init_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wr_b.size()) return {23'd0, wr_b[i]};
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] wcyc(input int i, input int j);
        if (i < wr_t.size() && j < wr_t.size()) return 32'((wr_t[j] - wr_t[i]) / PER);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] fcyc(input int i, input int j);
        if (i < fd_t.size() && j < fd_t.size()) return 32'((fd_t[j] - fd_t[i]) / PER);
        return 32'hDEAD;
    endfunction

    task automatic wait_wr(input int target, input int budget, input string tag);
        int k = 0;
        while (wr_b.size() < target && k < budget) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk(tag, (wr_b.size() >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_fd(input int target, input int budget, input string tag);
        int k = 0;
        while (fd_t.size() < target && k < budget) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk(tag, (fd_t.size() >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_en"}, {31'd0, LCD_EN}, 32'd0);
        chk({pfx, "_rs"}, {31'd0, LCD_RS}, 32'd0);
        chk({pfx, "_rw"}, {31'd0, LCD_RW}, 32'd0);
        chk({pfx, "_data"}, {24'd0, LCD_DATA}, 32'd0);
        chk({pfx, "_addr"}, {27'd0, char_addr}, 32'd0);
        chk({pfx, "_scr"}, {30'd0, screen_id}, 32'd0);
        chk({pfx, "_fd"}, {31'd0, frame_done}, 32'd0);
        chk({pfx, "_init"}, {31'd0, init_done}, 32'd0);
    endtask

    task automatic first_en(input string tag);
        int n = 0;
        logic [7:0] pw_data = 8'hFF;
        while (LCD_EN !== 1'b1 && n < 100) begin
            @(negedge CLOCK_50);
            n++;
            if (n == PWR - 1) pw_data = LCD_DATA;
        end
        // EN stays low through the power-up wait plus the first SETUP.
        chk({tag, "_first_en_cyc"}, 32'(n), 32'(PWR + SETUP));
        chk({tag, "_pwrup_data"}, {24'd0, pw_data}, 32'd0);
    endtask

    initial begin
        time t_rel;
        int  base;
        int  k;
        logic [7:0] icmd [4];
        icmd[0] = 8'h38; icmd[1] = 8'h0C; icmd[2] = 8'h06; icmd[3] = 8'h01;

        repeat (3) @(negedge CLOCK_50);
        chk_reset_outputs("rst0");

        rst = 1'b0;
        t_rel = $time;
        first_en("pw1");

        wait_wr(10, 2000, "tmo_wr10");
        done = 1'b1;
        wait_fd(1, 2000, "tmo_fd1");

        for (int i = 0; i < 4; i++) chk($sformatf("init_cmd%0d", i), wr_at(i), {24'd0, icmd[i]});
        chk("init_gap_38_0c", wcyc(0, 1), 32'd8);
        chk("init_gap_06_01", wcyc(2, 3), 32'd8);
        chk("init_gap_01_80", wcyc(3, 4), 32'd15);
        chk("init_done_time", (id_t.size() > 0) ? 32'((id_t[0] - t_rel) / PER) : 32'hDEAD, 32'd58);
        chk("f1_l1addr", wr_at(4), 32'h080);
        chk("f1_fetch_gap", wcyc(4, 5), 32'd10);
        for (int i = 0; i < 16; i++) chk($sformatf("f1_l1_c%0d", i), wr_at(5 + i), 32'h141 + 32'(i));
        chk("f1_l2addr", wr_at(21), 32'h0C0);
        for (int i = 0; i < 16; i++) chk($sformatf("f1_l2_c%0d", i), wr_at(22 + i), 32'h151 + 32'(i));
        chk("f1_fd_time", 32'((fd_t[0] - t_rel) / PER), 32'd395);
        chk("f1_scr", {30'd0, fd_s[0]}, 32'd0);

        wait_fd(3, 2000, "tmo_fd3");
        chk("f2_clear", wr_at(38), 32'h001);
        chk("f2_l1addr", wr_at(39), 32'h080);
        chk("f2_clr_gap", wcyc(38, 39), 32'd14);
        chk("f2_scr_wr", (wr_s.size() > 39) ? {30'd0, wr_s[39]} : 32'hDEAD, 32'd1);
        chk("f2_last_chr", wr_at(72), 32'h160);
        chk("f3_noclear", wr_at(73), 32'h080);
        chk("f2_scr", {30'd0, fd_s[1]}, 32'd1);
        chk("f3_scr", {30'd0, fd_s[2]}, 32'd1);
        chk("f2_len", fcyc(0, 1), 32'd352);
        chk("f3_len", fcyc(1, 2), 32'd338);

        wait_wr(80, 2000, "tmo_wr80");
        error = 1'b1;
        wait_fd(4, 2000, "tmo_fd4");
        chk("f4_clear", wr_at(107), 32'h001);
        chk("f4_l1addr", wr_at(108), 32'h080);
        chk("f4_scr", {30'd0, fd_s[3]}, 32'd2);
        chk("f4_len", fcyc(2, 3), 32'd352);

        // Set just after frame 4 ends. Frame 5 still sees done=1, error=0 in SEL.
        wait_wr(110, 2000, "tmo_wr110");
        error = 1'b0;
        wait_wr(144, 2000, "tmo_wr144");
        chk("f5_clear", wr_at(142), 32'h001);
        chk("f5_l1addr", wr_at(143), 32'h080);
        chk("f5_scr_wr", (wr_s.size() > 143) ? {30'd0, wr_s[143]} : 32'hDEAD, 32'd1);

        // Reset in the middle of an EN-high line-2 data write.
        k = 0;
        while (!(wr_b.size() >= 162 && LCD_EN === 1'b1 && LCD_RS === 1'b1 && char_addr >= 5'd16)
               && k < 2000) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk("tmo_l2_en", {31'd0, LCD_EN}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        chk("fd_count", 32'(fd_t.size()), 32'd4);
        repeat (3) @(negedge CLOCK_50);
        base = wr_b.size();
        rst = 1'b0;
        t_rel = $time;
        first_en("pw2");
        wait_wr(base + 5, 2000, "tmo_wr_re");
        for (int i = 0; i < 4; i++) chk($sformatf("re_init_cmd%0d", i), wr_at(base + i), {24'd0, icmd[i]});
        chk("re_init_done_time",
            (id_t.size() > 1) ? 32'((id_t[id_t.size() - 1] - t_rel) / PER) : 32'hDEAD, 32'd58);
        // First frame after init never clears, even though done=1 selects screen 1.
        chk("re_first_noclear", wr_at(base + 4), 32'h080);
        chk("re_scr", (wr_s.size() > base + 4) ? {30'd0, wr_s[base + 4]} : 32'hDEAD, 32'd1);

        chk("rw_always_0", 32'(rw_bad), 32'd0);
        chk("en_width", 32'(en_len_bad), 32'd0);
        chk("data_stable_en", 32'(stab_bad), 32'd0);
        chk("fd_one_cycle", 32'(fd_wide_bad), 32'd0);
        chk("addr_zero_fend", 32'(fd_addr_bad), 32'd0);
        chk("addr_matches_cell", 32'(addr_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
